if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- First-word-fall-through instruction queue between the fetch stage (pc/instruction source) and decode.
- Absorbs decode stalls so fetch keeps running; discards all buffered instructions on redirect (taken branch/jump).
- Each entry holds {pc, instr, misaligned flag}.
- Decode pops with a valid/ready handshake.

Parameters:
- PC_WIDTH, 32, width of pc fields.
- INSTR_WIDTH, 32, width of instruction word.
- DEPTH, 4, number of entries; power of 2, minimum 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  redirect; discard all entries and any same-cycle push.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue accepts; push occurs when in_valid && in_ready && !flush.
- in_pc  input  PC_WIDTH  pc of presented instruction.
- in_instr  input  INSTR_WIDTH  presented instruction word.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes; pop occurs when out_valid && out_ready && !flush.
- out_pc  output  PC_WIDTH  head pc; 0 when out_valid=0.
- out_instr  output  INSTR_WIDTH  head instruction; 0 when out_valid=0.
- out_misaligned  output  1  head pc[1:0]!=0; 0 when out_valid=0.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async): write pointer, read pointer and count = 0; out_valid=0; in_ready=1; out_pc/out_instr/out_misaligned=0. Storage contents are not reset. Reset asserted mid-operation drops all entries immediately.
- Storage: DEPTH-entry register array. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. count is explicit, range 0..DEPTH.
- in_ready = (count != DEPTH). This is combinational from state only, with no dependence on out_ready.
- out_valid = (count != 0). Head fields are driven combinationally from the entry at the read pointer.
- Latency: push in cycle N makes the entry visible at the output in cycle N+1 (FWFT).
- Push only: write entry at the write pointer, advance the write pointer, count+1.
- Pop only: advance the read pointer, count-1.
- Simultaneous push and pop (0<count<DEPTH): both pointers advance and count is unchanged.
- Full (count=DEPTH): in_ready=0; in_valid is ignored. A pop in that cycle does not enable a same-cycle push.
- Empty (count=0): out_valid=0; out_ready is ignored.
- Flush takes priority over everything:
  - Next edge sets pointers and count to 0.
  - Same-cycle push and pop are both suppressed.
  - out_valid is 0 the cycle after flush.
  - The next push after flush lands at entry 0.
- out_misaligned is computed at push time from in_pc[1:0] and stored per entry.
- Pointer wrap: after DEPTH pushes the write pointer returns to 0. Ordering remains strict FIFO across the wrap.

Optional Feature:
- Macro: IF_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When count=0 and in_valid=1 and flush=0, out_valid=1 and out_pc/out_instr/out_misaligned are taken combinationally from the inputs.
  - If out_ready=1 in that cycle, the instruction is consumed directly: no write, count stays 0.
  - If out_ready=0, it is pushed normally.
  - Zero-latency path when empty.
- Undefined: behaviour exactly as above, minimum one-cycle latency; no combinational in->out path.

Test Plan:
- Reset, then push pc=0x0,4,8,C (instr 0x00000013,0x00100093,0x00200113,0x00300193) with out_ready=0:
  - count reaches 4, in_ready=0.
  - Extra push of pc=0x10 is not stored.
  - Raise out_ready: outputs appear in order 0x0,4,8,C, one per cycle; then out_valid=0, count=0.
- Continuous stream with in_valid=out_ready=1 for 12 cycles starting pc=0x100:
  - count holds at 1, outputs pc 0x100..0x12C in order.
  - Pointers wrap 3 times without loss.
- Fill with 3 entries, then assert flush in the same cycle as in_valid=1 and out_ready=1:
  - Next cycle count=0, out_valid=0, out_pc=0.
  - Following push pc=0x200 appears at the output one cycle later.
- Push in_pc=0x102 -> out_misaligned=1 with out_pc=0x102 at the head; push 0x104 -> out_misaligned=0.
- Assert rst asynchronously while count=2 (between edges):
  - out_valid=0 and count=0 immediately; after release, first push pc=0x0 appears correctly.
- Empty queue, in_valid=1, in_pc=0x40, out_ready=1:
  - With IF_FETCH_QUEUE_BYPASS_EN: same-cycle out_valid=1, out_pc=0x40, count stays 0.
  - Without: out_valid=0 this cycle, out_pc=0x40 next cycle.

Source files
------------

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - FWFT fetch-to-decode instruction queue with flush on redirect
// Optional zero-latency empty bypass: IF_FETCH_QUEUE_BYPASS_EN.
module if_fetch_queue #(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_WIDTH-1:0]        in_pc,
   input  logic [INSTR_WIDTH-1:0]     in_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [INSTR_WIDTH-1:0]     out_instr,
   output logic                       out_misaligned,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_WIDTH-1:0]    mem_pc    [DEPTH];
   logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
   logic                   mem_mis   [DEPTH];

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [CW-1:0] cnt;
   logic          empty;
   logic          push;
   logic          pop;

   assign empty    = (cnt == '0);
   assign in_ready = (cnt != CW'(DEPTH));
   assign count    = cnt;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
   logic byp;
   logic byp_take;

   // An empty queue forwards the fetch beat straight to decode; it is stored only if decode stalls.
   assign byp      = empty && in_valid && !flush;
   assign byp_take = byp && out_ready;
   assign push     = in_valid && in_ready && !flush && !byp_take;
`else
   assign push     = in_valid && in_ready && !flush;
`endif
   assign pop      = !empty && out_ready && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately left unreset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wptr]    <= in_pc;
         mem_instr[wptr] <= in_instr;
         mem_mis[wptr]   <= |in_pc[1:0];
      end
   end

   always_comb begin
      out_valid      = 1'b0;
      out_pc         = '0;
      out_instr      = '0;
      out_misaligned = 1'b0;
      if (!empty) begin
         out_valid      = 1'b1;
         out_pc         = mem_pc[rptr];
         out_instr      = mem_instr[rptr];
         out_misaligned = mem_mis[rptr];
      end
`ifdef IF_FETCH_QUEUE_BYPASS_EN
      else if (byp) begin
         out_valid      = 1'b1;
         out_pc         = in_pc;
         out_instr      = in_instr;
         out_misaligned = |in_pc[1:0];
      end
`endif
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue (table vectors, sequences, random vs queue model)
module tb_if_fetch_queue;

   localparam int DEPTH = 4;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_instr = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_misaligned;
   logic [2:0]  count;

   int total = 0;
   int bad = 0;

   if_fetch_queue #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .out_misaligned(out_misaligned), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t model_q[$];

   typedef struct {
      bit          iv;
      logic [31:0] pc;
      logic [31:0] instr;
      bit          ordy;
      bit          fl;
      int          cnt;
      bit          ir;
      bit          ov;
      logic [31:0] opc;
      bit          mis;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input bit iv, input logic [31:0] pc, input logic [31:0] instr, input bit ordy,
                      input bit fl, input int cnt, input bit ir, input bit ov, input logic [31:0] opc,
                      input bit mis);
      vec_t v;
      v.iv = iv; v.pc = pc; v.instr = instr; v.ordy = ordy; v.fl = fl;
      v.cnt = cnt; v.ir = ir; v.ov = ov; v.opc = opc; v.mis = mis;
      vecs.push_back(v);
   endtask

   // Compare DUT outputs with the queue model, then advance the model by the rules of one clock edge.
   task automatic model_check_and_update();
      bit          ev;
      logic [31:0] epc;
      logic [31:0] ein;
      int          n;
      n   = model_q.size();
      ev  = (n != 0);
      epc = ev ? model_q[0].pc : 32'h0;
      ein = ev ? model_q[0].instr : 32'h0;
      if (BYP && n == 0 && in_valid && !flush) begin
         ev = 1'b1; epc = in_pc; ein = in_instr;
      end
      check("m_count", 64'(count), 64'(n));
      check("m_in_ready", 64'(in_ready), 64'(n != DEPTH));
      check("m_out_valid", 64'(out_valid), 64'(ev));
      check("m_out_pc", 64'(out_pc), 64'(epc));
      check("m_out_instr", 64'(out_instr), 64'(ein));
      check("m_out_mis", 64'(out_misaligned), 64'(ev && epc[1:0] != 2'b00));
      if (flush) begin
         model_q.delete();
      end else if (BYP && n == 0 && in_valid && out_ready) begin
         // consumed directly by decode
      end else begin
         if (n != 0 && out_ready) void'(model_q.pop_front());
         if (in_valid && n != DEPTH) begin
            ent_t e;
            e.pc = in_pc; e.instr = in_instr;
            model_q.push_back(e);
         end
      end
   endtask

   task automatic drive(input bit iv, input logic [31:0] pc, input logic [31:0] instr,
                        input bit ordy, input bit fl);
      in_valid = iv; in_pc = pc; in_instr = instr; out_ready = ordy; flush = fl;
   endtask

   // Inputs are applied just after a rising edge; outputs are sampled on the falling edge.
   task automatic finish_cycle();
      model_check_and_update();
      @(posedge clk);
      #1;
   endtask

   task automatic run_table();
      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].pc, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
         @(negedge clk);
         check($sformatf("t%0d_count", i), 64'(count), 64'(vecs[i].cnt));
         check($sformatf("t%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
         check($sformatf("t%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
         check($sformatf("t%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].opc));
         check($sformatf("t%0d_out_mis", i), 64'(out_misaligned), 64'(vecs[i].mis));
         finish_cycle();
      end
      vecs.delete();
   endtask

   initial begin
      logic [31:0] pc;
      // reset state
      #2;
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // fill to full, overflow attempt, pop while full (no push), drain in order
      add(1, 32'h0,  32'h00000013, 0, 0, 0, 1, BYP, 32'h0, 0);
      add(1, 32'h4,  32'h00100093, 0, 0, 1, 1, 1, 32'h0, 0);
      add(1, 32'h8,  32'h00200113, 0, 0, 2, 1, 1, 32'h0, 0);
      add(1, 32'hC,  32'h00300193, 0, 0, 3, 1, 1, 32'h0, 0);
      add(1, 32'h10, 32'h00400213, 0, 0, 4, 0, 1, 32'h0, 0);
      add(1, 32'h10, 32'h00400213, 1, 0, 4, 0, 1, 32'h0, 0);
      add(0, 32'h0,  32'h0,        1, 0, 3, 1, 1, 32'h4, 0);
      add(0, 32'h0,  32'h0,        1, 0, 2, 1, 1, 32'h8, 0);
      add(0, 32'h0,  32'h0,        1, 0, 1, 1, 1, 32'hC, 0);
      add(0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h0, 0);
      // flush with simultaneous push and pop, then first push after flush
      add(1, 32'h300, 32'hA0, 0, 0, 0, 1, BYP, BYP ? 32'h300 : 32'h0, 0);
      add(1, 32'h304, 32'hA1, 0, 0, 1, 1, 1, 32'h300, 0);
      add(1, 32'h308, 32'hA2, 0, 0, 2, 1, 1, 32'h300, 0);
      add(1, 32'h30C, 32'hA3, 1, 1, 3, 1, 1, 32'h300, 0);
      add(0, 32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0, 0);
      add(1, 32'h200, 32'hB0, 0, 0, 0, 1, BYP, BYP ? 32'h200 : 32'h0, 0);
      add(0, 32'h0,   32'h0,  1, 0, 1, 1, 1, 32'h200, 0);
      add(0, 32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0, 0);
      // misaligned flag stored per entry
      add(1, 32'h102, 32'hC0, 0, 0, 0, 1, BYP, BYP ? 32'h102 : 32'h0, BYP);
      add(1, 32'h104, 32'hC1, 1, 0, 1, 1, 1, 32'h102, 1);
      add(0, 32'h0,   32'h0,  1, 0, 1, 1, 1, 32'h104, 0);
      add(0, 32'h0,   32'h0,  0, 0, 0, 1, 0, 32'h0, 0);
      // empty queue with decode ready: bypass or one-cycle latency
      add(1, 32'h40, 32'hD0, 1, 0, 0, 1, BYP, BYP ? 32'h40 : 32'h0, 0);
      add(0, 32'h0,  32'h0,  1, 0, BYP ? 0 : 1, 1, !BYP, BYP ? 32'h0 : 32'h40, 0);
      add(0, 32'h0,  32'h0,  0, 0, 0, 1, 0, 32'h0, 0);
      run_table();

      // continuous stream over three pointer wraps
      for (int i = 0; i < 12; i++) begin
         pc = 32'h100 + 32'(4 * i);
         drive(1, pc, pc ^ 32'h5A5A0000, 1, 0);
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("s%0d_count", i), 64'(count), BYP ? 64'd0 : 64'd1);
            check($sformatf("s%0d_out_pc", i), 64'(out_pc), BYP ? 64'(pc) : 64'(pc - 32'd4));
         end
         finish_cycle();
      end
      drive(0, 32'h0, 32'h0, 1, 0);
      @(negedge clk);
      check("s_last_pc", 64'(out_pc), BYP ? 64'd0 : 64'h12C);
      finish_cycle();
      drive(0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      check("s_drained", 64'(count), 64'd0);
      finish_cycle();

      // asynchronous reset between edges with two entries held
      drive(1, 32'h500, 32'hE0, 0, 0);
      finish_cycle();
      drive(1, 32'h504, 32'hE1, 0, 0);
      finish_cycle();
      drive(0, 32'h0, 32'h0, 0, 0);
      #1;
      check("ar_pre_count", 64'(count), 64'd2);
      rst = 1'b1;
      #1;
      check("ar_count", 64'(count), 64'd0);
      check("ar_out_valid", 64'(out_valid), 64'd0);
      check("ar_in_ready", 64'(in_ready), 64'd1);
      #1;
      rst = 1'b0;
      model_q.delete();
      drive(1, 32'h0, 32'h00000013, 0, 0);
      finish_cycle();
      drive(0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      check("ar_after_pc", 64'(out_pc), 64'd0);
      check("ar_after_instr", 64'(out_instr), 64'h13);
      check("ar_after_valid", 64'(out_valid), 64'd1);
      finish_cycle();

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         pc = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
         drive($urandom_range(0, 3) != 0, pc, $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 19) == 0);
         @(negedge clk);
         finish_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
